// File: rtl/read_mem_cmd.sv
// Mailbox consumer: polls the command byte in data memory, fetches the start
// position, offers both to the core with valid/ready, then clears the mailbox.
module read_mem_cmd #(
    parameter int          RD_LATENCY    = 1,
    parameter int          POLL_INTERVAL = 16,
    parameter logic [15:0] CMD_ADDR      = 16'h0000,
    parameter logic [15:0] POS_ADDR      = 16'h0001
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [7:0]  mem_rdata,
    output logic        mem_wr_en,
    output logic [7:0]  mem_wdata,
    output logic        cmd_valid,
    output logic [1:0]  cmd_algo,
    output logic [7:0]  cmd_pos,
    input  logic        cmd_ready,
    output logic        cmd_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_CMD = 3'd1;
    localparam logic [2:0] S_RD_POS = 3'd2;
    localparam logic [2:0] S_OFFER  = 3'd3;
    localparam logic [2:0] S_CLEAR  = 3'd4;

    localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);
    localparam logic [15:0] LAT_LAST  = 16'(RD_LATENCY);

    logic [2:0]  state_r;
    logic [15:0] cnt_r;

    // The clear write only ever stores zero.
    assign mem_wdata = 8'd0;

    // Mailbox FSM; every output is a register, strobes default low each cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            cnt_r     <= 16'd0;
            mem_addr  <= 16'd0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_algo  <= 2'd0;
            cmd_pos   <= 8'd0;
            cmd_err   <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            cmd_err   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (cnt_r == POLL_LAST) begin
                        cnt_r     <= 16'd0;
                        state_r   <= S_RD_CMD;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= CMD_ADDR;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                // cnt_r counts cycles since the strobe; data is valid at RD_LATENCY.
                S_RD_CMD: begin
                    if (cnt_r == LAT_LAST) begin
                        cnt_r <= 16'd0;
                        if (mem_rdata == 8'd0) begin
                            state_r <= S_IDLE;
                        end else if (mem_rdata == 8'd1 || mem_rdata == 8'd2) begin
                            cmd_algo  <= mem_rdata[1:0];
                            state_r   <= S_RD_POS;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= POS_ADDR;
                        end else begin
                            cmd_err   <= 1'b1;
                            state_r   <= S_CLEAR;
                            mem_wr_en <= 1'b1;
                            mem_addr  <= CMD_ADDR;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                S_RD_POS: begin
                    if (cnt_r == LAT_LAST) begin
                        cnt_r     <= 16'd0;
                        cmd_pos   <= mem_rdata;
                        cmd_valid <= 1'b1;
                        state_r   <= S_OFFER;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                S_OFFER: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state_r   <= S_CLEAR;
                        mem_wr_en <= 1'b1;
                        mem_addr  <= CMD_ADDR;
                    end else begin
                        cmd_valid <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    cnt_r   <= 16'd0;
                    state_r <= S_IDLE;
                end
                default: begin
                    cnt_r     <= 16'd0;
                    cmd_valid <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
